// File: rtl/matmul_sequencer.sv
// Control sequencer for the matmul PE array: latches the operand shape on start,
// clears the accumulators, streams skewed feed steps, then writes result rows out.
module matmul_sequencer #(
   parameter int DATA_WIDTH  = 16,
   parameter int BUS_WIDTH   = 32,
   parameter int SP_NTARGETS = 1,
   parameter int K_WIDTH     = 8,
   parameter int SPT_W       = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1,
   parameter int DIM_W       = $clog2(BUS_WIDTH / DATA_WIDTH) + 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [DIM_W-1:0]   n_i,
   input  logic [K_WIDTH-1:0] k_i,
   input  logic [DIM_W-1:0]   m_i,
   input  logic [SPT_W-1:0]   sp_target_i,
   output logic               pe_clear_o,
   output logic               pe_en_o,
   output logic [K_WIDTH+1:0] feed_idx_o,
   output logic               wr_valid_o,
   input  logic               wr_ready_i,
   output logic [DIM_W-1:0]   wr_row_o,
   output logic [SPT_W-1:0]   wr_target_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               err_o
);

   localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
   localparam int FW      = K_WIDTH + 2;

   localparam logic [DIM_W-1:0] MaxDimV     = DIM_W'(MAX_DIM);
   localparam logic [SPT_W:0]   NTargetsV   = (SPT_W + 1)'(SP_NTARGETS);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      WRITE,
      DONE
   } seqStateT;

   seqStateT           stateReg;
   seqStateT           stateNext;

   logic [DIM_W-1:0]   nReg;
   logic [K_WIDTH-1:0] kReg;
   logic [DIM_W-1:0]   mReg;
   logic [SPT_W-1:0]   targetReg;
   logic [FW-1:0]      feedCnt;
   logic [DIM_W-1:0]   rowCnt;
   logic               errReg;

   logic               cfgLegal;
   logic [FW-1:0]      lastStep;
   logic               feedLast;
   logic               lastRow;

   // Shape check on the raw inputs; only meaningful while IDLE samples start_i.
   always_comb begin
      cfgLegal = (n_i != '0) && (n_i <= MaxDimV) &&
                 (m_i != '0) && (m_i <= MaxDimV) &&
                 (k_i != '0) &&
                 ({1'b0, sp_target_i} < NTargetsV);
   end

   // The feed phase lasts k+n+m-2 steps to fill and drain the skewed array.
   always_comb begin
      lastStep = FW'(kReg) + FW'(nReg) + FW'(mReg) - FW'(3);
      feedLast = (feedCnt == lastStep);
      lastRow  = (rowCnt == nReg - DIM_W'(1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stateReg <= IDLE;
      end else begin
         stateReg <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      case (stateReg)
         IDLE:    if (start_i && cfgLegal) stateNext = CLEAR;
         CLEAR:   stateNext = FEED;
         FEED:    if (feedLast) stateNext = WRITE;
         WRITE:   if (wr_ready_i && lastRow) stateNext = DONE;
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Configuration latch, step/row counters and the sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nReg      <= '0;
         kReg      <= '0;
         mReg      <= '0;
         targetReg <= '0;
         feedCnt   <= '0;
         rowCnt    <= '0;
         errReg    <= 1'b0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (start_i) begin
                  if (cfgLegal) begin
                     nReg      <= n_i;
                     kReg      <= k_i;
                     mReg      <= m_i;
                     targetReg <= sp_target_i;
                     feedCnt   <= '0;
                     rowCnt    <= '0;
                     errReg    <= 1'b0;
                  end else begin
                     errReg    <= 1'b1;
                  end
               end
            end
            FEED: begin
               feedCnt <= feedCnt + FW'(1);
            end
            WRITE: begin
               if (wr_ready_i) begin
                  rowCnt <= rowCnt + DIM_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decode purely from state so an async reset zeroes them at once.
   always_comb begin
      pe_clear_o  = 1'b0;
      pe_en_o     = 1'b0;
      feed_idx_o  = '0;
      wr_valid_o  = 1'b0;
      wr_row_o    = '0;
      busy_o      = (stateReg != IDLE);
      done_o      = 1'b0;
      wr_target_o = targetReg;
      err_o       = errReg;
      case (stateReg)
         CLEAR: pe_clear_o = 1'b1;
         FEED: begin
            pe_en_o    = 1'b1;
            feed_idx_o = feedCnt;
         end
         WRITE: begin
            wr_valid_o = 1'b1;
            wr_row_o   = rowCnt;
         end
         DONE:    done_o = 1'b1;
         default: begin
         end
      endcase
   end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control FSM for the matmul accelerator's processing-element (PE) array: on a start pulse it latches the operand dimensions, clears the PE accumulators, and streams the skewed feed-step index to the operand feeders. It then writes each result row to the selected scratchpad target through a valid/ready port and signals completion. It sits between the register-file/start logic and the PE array plus scratchpad write path.

## Interface
- DATA_WIDTH, 16, element width (informational; no datapath here)
- BUS_WIDTH, 32, bus width; MAX_DIM = BUS_WIDTH/DATA_WIDTH (= 2)
- SP_NTARGETS, 1, number of scratchpad targets; SPT_W = max(1, $clog2(SP_NTARGETS))
- K_WIDTH, 8, width of the K dimension field
- DIM_W, $clog2(MAX_DIM)+1, width of the N/M fields
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start request; sampled only in IDLE
- n_i  in  DIM_W  rows of A, legal 1..MAX_DIM
- k_i  in  K_WIDTH  cols of A / rows of B, legal 1..2^K_WIDTH-1
- m_i  in  DIM_W  cols of B, legal 1..MAX_DIM
- sp_target_i  in  SPT_W  destination scratchpad, legal < SP_NTARGETS
- pe_clear_o  out  1  clear all PE accumulators
- pe_en_o  out  1  PE array shift/accumulate enable
- feed_idx_o  out  K_WIDTH+2  current feed step, 0..F-1
- wr_valid_o  out  1  result row write request
- wr_ready_i  in  1  scratchpad accepts write
- wr_row_o  out  DIM_W  result row index
- wr_target_o  out  SPT_W  latched sp_target_i
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  sticky illegal-configuration flag

## Operation
- States: IDLE, CLEAR, FEED, WRITE, DONE.
- IDLE: start_i=1 with legal config -> latch n, k, m, target; clear err_o; go to CLEAR. Illegal config (n/m = 0 or > MAX_DIM, k = 0, target >= SP_NTARGETS) -> set err_o, stay IDLE. err_o holds until the next legal start.
- start_i outside IDLE is ignored; it is neither queued nor flagged.
- CLEAR: pe_clear_o=1 for exactly 1 cycle, then FEED.
- FEED: pe_en_o=1 for F = k + n + m - 2 cycles (systolic skew fill and drain); feed_idx_o counts 0..F-1, computed at K_WIDTH+2 bits with no overflow. After step F-1, go to WRITE.
- WRITE: wr_valid_o=1 and wr_row_o = r for r = 0..n-1. r advances on the cycle wr_valid_o && wr_ready_i. wr_valid_o stays asserted and wr_row_o stays stable until accepted. After row n-1 is accepted, go to DONE.
- DONE: done_o=1 for 1 cycle, then IDLE.
- busy_o = 1 in CLEAR, FEED, WRITE, DONE.
- Reset value of every output is 0. Latched registers also reset to 0.
- Async reset asserted mid-run: FSM returns to IDLE and outputs drop to 0 immediately, without waiting for a clock edge. No done_o is emitted. Any partial write is abandoned.

## Timing
- Edge 0 samples start_i; CLEAR during cycle 1; FEED during cycles 2..F+1.
- First wr_valid_o in cycle F+2.
- With wr_ready_i tied high: row r is written in cycle F+2+r; done_o in cycle F+2+n.
- Total start-to-done latency with no backpressure: F+2+n cycles.
- Each cycle wr_ready_i is low during WRITE adds 1 cycle.
- A start_i in the DONE cycle is ignored. A start_i in the first IDLE cycle after DONE is accepted (back-to-back runs, 1 idle cycle between).
- err_o is set/cleared on the same edge that samples start_i.

## Test plan
- n=2, k=4, m=1, ready tied high, start at edge 0:
  - pe_clear_o in cycle 1; pe_en_o in cycles 2..6 (F=5), feed_idx_o 0..4.
  - Rows 0 and 1 written in cycles 7 and 8; done_o in cycle 9; busy_o high in cycles 1..9.
- n=2, k=1, m=2, wr_ready_i low for the first 3 WRITE cycles:
  - F=3; row 0 is held stable for 4 cycles; row 1 is accepted in the following cycle.
  - done_o is 3 cycles later than in the no-stall case.
- Illegal configs, each with start:
  - n=0, k=4, m=1: err_o=1, busy_o stays 0, no pe_clear_o.
  - n=3 or k=0: err_o=1, busy_o stays 0, no pe_clear_o.
  - A following legal start clears err_o and completes normally.
- start_i pulsed during FEED and during DONE:
  - No effect on the run; exactly one done_o.
  - A start in the cycle after DONE begins a second run.
- rst_ni dropped mid-FEED (n=2, k=8, m=2), asynchronously between edges:
  - All outputs read 0 before the next edge.
  - After release, IDLE; a new start runs cleanly.
- n=1, k=1, m=1 (minimum): F=1; clear in cycle 1, feed in cycle 2, row 0 in cycle 3, done_o in cycle 4.
